sparse_sd_gen: RTL

SPARSE_SD_GEN -- requirements
Module: sparse_sd_gen

---
 rtl/sparse_sd_gen_if.sv | 40 ++++
 rtl/sparse_sd_gen.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sparse_sd_gen_if.sv
// Tile-load and entry-stream bus for sparse_sd_gen.
interface sparse_sd_gen_if #(
  parameter int unsigned W_ROWS = 8,
  parameter int unsigned K      = 4,
  parameter int unsigned I_COLS = 8
);
  localparam int unsigned RW = (W_ROWS > 1) ? $clog2(W_ROWS) : 1;
  localparam int unsigned CW = (I_COLS > 1) ? $clog2(I_COLS) : 1;
  localparam int unsigned SW = (K * I_COLS > 1) ? $clog2(K * I_COLS) : 1;
  localparam int unsigned DW = (W_ROWS * K > 1) ? $clog2(W_ROWS * K) : 1;
  localparam int unsigned NW = $clog2(W_ROWS * K * I_COLS + 1);

  logic                  load_valid;
  logic                  load_ready;
  logic [W_ROWS*K-1:0]   w_bitmap;
  logic [K*I_COLS-1:0]   i_bitmap;
  logic                  abort;
  logic                  out_valid;
  logic                  out_ready;
  logic [CW-1:0]         out_col;
  logic [RW-1:0]         out_id;
  logic [SW-1:0]         out_src;
  logic [DW-1:0]         out_dest;
  logic                  out_last;
  logic [DW:0]           stat_count;
  logic [NW-1:0]         entry_count;
  logic                  tile_done;

  modport master (
    output load_valid, w_bitmap, i_bitmap, abort, out_ready,
    input  load_ready, out_valid, out_col, out_id, out_src, out_dest,
           out_last, stat_count, entry_count, tile_done
  );

  modport slave (
    input  load_valid, w_bitmap, i_bitmap, abort, out_ready,
    output load_ready, out_valid, out_col, out_id, out_src, out_dest,
           out_last, stat_count, entry_count, tile_done
  );
endinterface

// File: rtl/sparse_sd_gen.sv
// Sparse src/dest table generator: scans (c,k,r) over a stationary bitmap w
// and a streaming bitmap i, emitting one entry per matching nonzero pair.
// Optional macro SD_ROW_SKIP_EN drops stationary bits whose shared-dimension
// row of i is all zero before ranking.
module sparse_sd_gen #(
  parameter int unsigned W_ROWS = 8,
  parameter int unsigned K      = 4,
  parameter int unsigned I_COLS = 8
) (
  input logic            clk,
  input logic            rst,
  sparse_sd_gen_if.slave bus
);
  localparam int unsigned RW  = (W_ROWS > 1) ? $clog2(W_ROWS) : 1;
  localparam int unsigned CW  = (I_COLS > 1) ? $clog2(I_COLS) : 1;
  localparam int unsigned SW  = (K * I_COLS > 1) ? $clog2(K * I_COLS) : 1;
  localparam int unsigned DW  = (W_ROWS * K > 1) ? $clog2(W_ROWS * K) : 1;
  localparam int unsigned NW  = $clog2(W_ROWS * K * I_COLS + 1);
  localparam int unsigned KW  = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned SCW = DW + 1;
  localparam int unsigned WB  = W_ROWS * K;
  localparam int unsigned IB  = K * I_COLS;

  typedef enum logic [1:0] {IDLE, PREP, SCAN, DONE} state_t;

  state_t          state_q, state_nxt;
  logic [WB-1:0]   w_q, w_nxt;
  logic [IB-1:0]   i_q, i_nxt;
  logic [WB-1:0]   keep_q, keep_nxt, keep_c;
  logic [DW-1:0]   dest_q [WB];
  logic [DW-1:0]   dest_nxt [WB];
  logic [DW-1:0]   dest_c [WB];
  logic [NW-1:0]   total_q, total_nxt, total_c;
  logic [SCW-1:0]  stat_c;
  logic [NW-1:0]   emit_q, emit_nxt;
  logic [CW-1:0]   c_q, c_nxt;
  logic [KW-1:0]   k_q, k_nxt;
  logic [RW-1:0]   r_q, r_nxt;
  logic [SW-1:0]   src_q, src_nxt;
  logic            scan_end_q, scan_end_nxt;

  logic            load_ready_q, load_ready_nxt;
  logic            out_valid_q, out_valid_nxt;
  logic [CW-1:0]   out_col_q, out_col_nxt;
  logic [RW-1:0]   out_id_q, out_id_nxt;
  logic [SW-1:0]   out_src_q, out_src_nxt;
  logic [DW-1:0]   out_dest_q, out_dest_nxt;
  logic            out_last_q, out_last_nxt;
  logic [SCW-1:0]  stat_count_q, stat_count_nxt;
  logic [NW-1:0]   entry_count_q, entry_count_nxt;
  logic            tile_done_q, tile_done_nxt;

  logic            hs, stall, hit;
  logic [DW-1:0]   w_idx;
  logic [SW-1:0]   i_idx;

  // Keep mask, row-major rank of each kept bit, kept count and entry total.
  always_comb begin
    int unsigned rank;
    int unsigned tot;
    int unsigned col_keep;
    rank   = 0;
    tot    = 0;
    keep_c = '0;
    for (int unsigned r = 0; r < W_ROWS; r++) begin
      for (int unsigned k = 0; k < K; k++) begin
`ifdef SD_ROW_SKIP_EN
        keep_c[r*K+k] = w_q[r*K+k] & (|i_q[k*I_COLS +: I_COLS]);
`else
        keep_c[r*K+k] = w_q[r*K+k];
`endif
        dest_c[r*K+k] = DW'(rank);
        if (keep_c[r*K+k]) rank = rank + 1;
      end
    end
    for (int unsigned k = 0; k < K; k++) begin
      col_keep = 0;
      for (int unsigned r = 0; r < W_ROWS; r++) begin
        if (keep_c[r*K+k]) col_keep = col_keep + 1;
      end
      for (int unsigned c = 0; c < I_COLS; c++) begin
        if (i_q[k*I_COLS+c]) tot = tot + col_keep;
      end
    end
    stat_c  = SCW'(rank);
    total_c = NW'(tot);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt       = state_q;
    w_nxt           = w_q;
    i_nxt           = i_q;
    keep_nxt        = keep_q;
    dest_nxt        = dest_q;
    total_nxt       = total_q;
    emit_nxt        = emit_q;
    c_nxt           = c_q;
    k_nxt           = k_q;
    r_nxt           = r_q;
    src_nxt         = src_q;
    scan_end_nxt    = scan_end_q;
    load_ready_nxt  = load_ready_q;
    out_valid_nxt   = out_valid_q;
    out_col_nxt     = out_col_q;
    out_id_nxt      = out_id_q;
    out_src_nxt     = out_src_q;
    out_dest_nxt    = out_dest_q;
    out_last_nxt    = out_last_q;
    stat_count_nxt  = stat_count_q;
    entry_count_nxt = entry_count_q;
    tile_done_nxt   = 1'b0;

    hs    = out_valid_q & bus.out_ready;
    stall = out_valid_q & ~bus.out_ready;
    w_idx = DW'(32'(r_q) * K + 32'(k_q));
    i_idx = SW'(32'(k_q) * I_COLS + 32'(c_q));
    hit   = i_q[i_idx] & keep_q[w_idx];

    case (state_q)
      IDLE: begin
        if (bus.load_valid) begin
          state_nxt       = PREP;
          w_nxt           = bus.w_bitmap;
          i_nxt           = bus.i_bitmap;
          load_ready_nxt  = 1'b0;
          entry_count_nxt = '0;
        end
      end
      PREP: begin
        state_nxt      = SCAN;
        keep_nxt       = keep_c;
        dest_nxt       = dest_c;
        total_nxt      = total_c;
        stat_count_nxt = stat_c;
        c_nxt          = '0;
        k_nxt          = '0;
        r_nxt          = '0;
        src_nxt        = '0;
        emit_nxt       = '0;
        scan_end_nxt   = 1'b0;
      end
      SCAN: begin
        if (hs) entry_count_nxt = entry_count_q + NW'(1);
        if (!stall) begin
          if (!scan_end_q) begin
            out_valid_nxt = hit;
            out_last_nxt  = hit & (emit_q == total_q - NW'(1));
            if (hit) begin
              out_col_nxt  = c_q;
              out_id_nxt   = r_q;
              out_src_nxt  = src_q;
              out_dest_nxt = dest_q[w_idx];
              emit_nxt     = emit_q + NW'(1);
            end
            // Advance r inner, k middle, c outer; src counts i ones passed.
            if (r_q == RW'(W_ROWS - 1)) begin
              r_nxt = '0;
              if (i_q[i_idx]) src_nxt = src_q + SW'(1);
              if (k_q == KW'(K - 1)) begin
                k_nxt = '0;
                if (c_q == CW'(I_COLS - 1)) scan_end_nxt = 1'b1;
                else c_nxt = c_q + CW'(1);
              end else begin
                k_nxt = k_q + KW'(1);
              end
            end else begin
              r_nxt = r_q + RW'(1);
            end
          end else begin
            out_valid_nxt = 1'b0;
            out_last_nxt  = 1'b0;
            state_nxt     = DONE;
          end
        end
      end
      DONE: begin
        state_nxt      = IDLE;
        load_ready_nxt = 1'b1;
        tile_done_nxt  = 1'b1;
      end
      default: begin
        state_nxt      = IDLE;
        load_ready_nxt = 1'b1;
      end
    endcase

    // Abort discards the tile; a coincident handshake is dropped.
    if (state_q != IDLE && bus.abort) begin
      state_nxt       = IDLE;
      load_ready_nxt  = 1'b1;
      out_valid_nxt   = 1'b0;
      out_last_nxt    = 1'b0;
      tile_done_nxt   = 1'b0;
      entry_count_nxt = entry_count_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      w_q           <= '0;
      i_q           <= '0;
      keep_q        <= '0;
      dest_q        <= '{default: '0};
      total_q       <= '0;
      emit_q        <= '0;
      c_q           <= '0;
      k_q           <= '0;
      r_q           <= '0;
      src_q         <= '0;
      scan_end_q    <= 1'b0;
      load_ready_q  <= 1'b1;
      out_valid_q   <= 1'b0;
      out_col_q     <= '0;
      out_id_q      <= '0;
      out_src_q     <= '0;
      out_dest_q    <= '0;
      out_last_q    <= 1'b0;
      stat_count_q  <= '0;
      entry_count_q <= '0;
      tile_done_q   <= 1'b0;
    end else begin
      state_q       <= state_nxt;
      w_q           <= w_nxt;
      i_q           <= i_nxt;
      keep_q        <= keep_nxt;
      dest_q        <= dest_nxt;
      total_q       <= total_nxt;
      emit_q        <= emit_nxt;
      c_q           <= c_nxt;
      k_q           <= k_nxt;
      r_q           <= r_nxt;
      src_q         <= src_nxt;
      scan_end_q    <= scan_end_nxt;
      load_ready_q  <= load_ready_nxt;
      out_valid_q   <= out_valid_nxt;
      out_col_q     <= out_col_nxt;
      out_id_q      <= out_id_nxt;
      out_src_q     <= out_src_nxt;
      out_dest_q    <= out_dest_nxt;
      out_last_q    <= out_last_nxt;
      stat_count_q  <= stat_count_nxt;
      entry_count_q <= entry_count_nxt;
      tile_done_q   <= tile_done_nxt;
    end
  end

  assign bus.load_ready  = load_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_col     = out_col_q;
  assign bus.out_id      = out_id_q;
  assign bus.out_src     = out_src_q;
  assign bus.out_dest    = out_dest_q;
  assign bus.out_last    = out_last_q;
  assign bus.stat_count  = stat_count_q;
  assign bus.entry_count = entry_count_q;
  assign bus.tile_done   = tile_done_q;
endmodule
